// File: rtl/dsp_mac_sequencer.sv
// Job-level controller for the fractured DSP MAC slice: buffers a job's operand
// pairs, issues them back-to-back so mac chaining is unbroken, and returns the result.
module dsp_mac_sequencer #(
    parameter int WIDTH         = 33,
    parameter int SHIFT_BITS    = 2,
    parameter int PIPELINE_BITS = 3,
    parameter int DEPTH         = 8,
    parameter int CNT_BITS      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [1:0]               cfg_mode,
    input  logic [CNT_BITS-1:0]      cfg_len,
    input  logic [2*WIDTH-1:0]       cfg_cc,
    input  logic [SHIFT_BITS-1:0]    cfg_shift_amount,
    input  logic                     cfg_shift_dir,
    input  logic [PIPELINE_BITS-1:0] cfg_pipe,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [WIDTH-1:0]         op_a,
    input  logic [WIDTH-1:0]         op_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2*WIDTH-1:0]       res_data,
    output logic                     busy,
    output logic                     dsp_start,
    output logic                     dsp_mac,
    output logic [1:0]               dsp_mode,
    output logic [SHIFT_BITS-1:0]    dsp_shift_amount,
    output logic                     dsp_shift_dir,
    output logic [PIPELINE_BITS-1:0] dsp_pipe_stages,
    output logic [WIDTH-1:0]         dsp_aa,
    output logic [WIDTH-1:0]         dsp_bb,
    output logic [2*WIDTH-1:0]       dsp_cc,
    input  logic [2*WIDTH-1:0]       dsp_out
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [1:0]               mode;
        logic [CNT_BITS-1:0]      len;
        logic [2*WIDTH-1:0]       cc;
        logic [SHIFT_BITS-1:0]    shamt;
        logic                     dir;
        logic [PIPELINE_BITS-1:0] pipe;
    } job_t;

    state_t                   state, state_nx;
    job_t                     job;
    logic [2*WIDTH-1:0]       buf_mem [DEPTH];
    logic [CNT_BITS-1:0]      wr_ptr, idx, len_m1, len_c;
    logic [PIPELINE_BITS-1:0] drain_cnt, pipe_c;
    logic [2*WIDTH-1:0]       res_q;
    logic                     capture, issue_last;

    always_comb begin
        len_c = cfg_len;
        if (cfg_len == '0)
            len_c = CNT_BITS'(1);
        else if (cfg_len > CNT_BITS'(DEPTH))
            len_c = CNT_BITS'(DEPTH);
        pipe_c = cfg_pipe;
        if (cfg_pipe > PIPELINE_BITS'(PIPELINE_BITS))
            pipe_c = PIPELINE_BITS'(PIPELINE_BITS);
    end

    assign len_m1     = job.len - CNT_BITS'(1);
    assign issue_last = (idx == len_m1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cfg_ready = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        dsp_start = 1'b0;
        dsp_mac   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = !rst;
                if (cfg_valid) state_nx = LOAD;
            end
            LOAD: begin
                op_ready = 1'b1;
                if (op_valid && wr_ptr == len_m1) state_nx = SETUP;
            end
            // One quiet cycle so the DSP sees mac_prev=0 on the first issue.
            SETUP: state_nx = ISSUE;
            ISSUE: begin
                dsp_start = 1'b1;
                dsp_mac   = 1'b1;
                if (issue_last) begin
                    if (job.pipe == '0) begin
                        capture  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == PIPELINE_BITS'(1)) begin
                    capture  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (op_valid && op_ready)
            buf_mem[wr_ptr[AW-1:0]] <= {op_a, op_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            job       <= '0;
            wr_ptr    <= '0;
            idx       <= '0;
            drain_cnt <= '0;
            res_q     <= '0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                job.mode  <= cfg_mode;
                job.len   <= len_c;
                job.cc    <= cfg_cc;
                job.shamt <= cfg_shift_amount;
                job.dir   <= cfg_shift_dir;
                job.pipe  <= pipe_c;
                wr_ptr    <= '0;
                idx       <= '0;
            end
            if (op_valid && op_ready)
                wr_ptr <= wr_ptr + CNT_BITS'(1);
            if (state == ISSUE) begin
                idx <= idx + CNT_BITS'(1);
                if (issue_last) drain_cnt <= job.pipe;
            end
            if (state == DRAIN)
                drain_cnt <= drain_cnt - PIPELINE_BITS'(1);
            if (capture)
                res_q <= dsp_out;
        end
    end

    assign {dsp_aa, dsp_bb}  = (state == ISSUE) ? buf_mem[idx[AW-1:0]] : '0;
    assign dsp_mode          = job.mode;
    assign dsp_cc            = job.cc;
    assign dsp_shift_amount  = job.shamt;
    assign dsp_shift_dir     = job.dir;
    assign dsp_pipe_stages   = job.pipe;
    assign res_data          = res_q;
    assign busy              = (state != IDLE);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a small behavioural DSP slice model.
module tb_dsp_mac_sequencer;
    localparam int W = 33, SB = 2, PB = 3, D = 8, CB = 4;

    logic            clk = 1'b0, rst = 1'b1;
    logic            cfg_valid = 1'b0, cfg_ready;
    logic [1:0]      cfg_mode = '0;
    logic [CB-1:0]   cfg_len = '0;
    logic [2*W-1:0]  cfg_cc = '0;
    logic [SB-1:0]   cfg_shift_amount = '0;
    logic            cfg_shift_dir = 1'b0;
    logic [PB-1:0]   cfg_pipe = '0;
    logic            op_valid = 1'b0, op_ready;
    logic [W-1:0]    op_a = '0, op_b = '0;
    logic            res_valid, res_ready = 1'b1;
    logic [2*W-1:0]  res_data;
    logic            busy, dsp_start, dsp_mac, dsp_shift_dir;
    logic [1:0]      dsp_mode;
    logic [SB-1:0]   dsp_shift_amount;
    logic [PB-1:0]   dsp_pipe_stages;
    logic [W-1:0]    dsp_aa, dsp_bb;
    logic [2*W-1:0]  dsp_cc, dsp_out;

    dsp_mac_sequencer #(.WIDTH(W), .SHIFT_BITS(SB), .PIPELINE_BITS(PB), .DEPTH(D), .CNT_BITS(CB)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .cfg_cc(cfg_cc), .cfg_shift_amount(cfg_shift_amount), .cfg_shift_dir(cfg_shift_dir),
        .cfg_pipe(cfg_pipe), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
        .dsp_start(dsp_start), .dsp_mac(dsp_mac), .dsp_mode(dsp_mode),
        .dsp_shift_amount(dsp_shift_amount), .dsp_shift_dir(dsp_shift_dir),
        .dsp_pipe_stages(dsp_pipe_stages), .dsp_aa(dsp_aa), .dsp_bb(dsp_bb),
        .dsp_cc(dsp_cc), .dsp_out(dsp_out)
    );

    always #5 clk = ~clk;

    // DSP slice: chained accumulate with selectable output depth.
    logic signed [2*W-1:0] acc = '0, s, shifted;
    logic signed [2*W-1:0] pq [8];
    logic                  mac_prev = 1'b0;

    always_comb begin
        shifted = dsp_shift_dir ? (acc <<< dsp_shift_amount) : (acc >>> dsp_shift_amount);
        s = $signed(dsp_aa) * $signed(dsp_bb) + (mac_prev ? shifted : $signed(dsp_cc));
        dsp_out = (dsp_pipe_stages == '0) ? s : pq[dsp_pipe_stages - 3'd1];
    end

    always @(posedge clk) begin
        mac_prev <= dsp_mac;
        if (dsp_start) acc <= s;
        pq[0] <= s;
        for (int i = 1; i < 8; i++) pq[i] <= pq[i-1];
    end

    int cyc = 0, n_chk = 0, n_err = 0, last_l = 0;
    int st_cnt = 0, st_runs = 0, pipe_seen = 0;
    logic setup_mac = 1'b0, prev_start = 1'b0, prev_mac = 1'b0;
    logic signed [W-1:0] va [8], vb [8];
    logic [2*W-1:0] r;
    int lat;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dsp_start) begin
            st_cnt++;
            pipe_seen = int'(dsp_pipe_stages);
            if (!prev_start) begin
                st_runs++;
                setup_mac = prev_mac;
            end
        end
        prev_start = dsp_start;
        prev_mac   = dsp_mac;
    end

    task automatic check(input string tag, input logic signed [127:0] got, input logic signed [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_cfg(input int mode, input int len, input int cc, input int shamt,
                            input int dir, input int pipe);
        int t = 0;
        @(negedge clk);
        st_cnt = 0; st_runs = 0; setup_mac = 1'b1; pipe_seen = -1;
        cfg_mode = 2'(mode); cfg_len = CB'(len); cfg_cc = 66'(signed'(cc));
        cfg_shift_amount = SB'(shamt); cfg_shift_dir = 1'(dir); cfg_pipe = PB'(pipe);
        cfg_valid = 1'b1;
        while (!cfg_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("cfg_timeout", 0, 1);
        @(posedge clk); #1 cfg_valid = 1'b0;
    endtask

    task automatic send_ops(input int n, input int gap);
        int t;
        for (int i = 0; i < n; i++) begin
            repeat (gap) @(negedge clk);
            @(negedge clk);
            op_valid = 1'b1; op_a = va[i]; op_b = vb[i];
            t = 0;
            while (!op_ready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) check("op_timeout", 0, 1);
            last_l = cyc;
            @(posedge clk); #1 op_valid = 1'b0;
        end
    endtask

    task automatic wait_res(output logic [2*W-1:0] rd, output int lt);
        int t = 0;
        @(negedge clk);
        while (!res_valid && t < 60) begin @(negedge clk); t++; end
        if (t >= 60) check("res_timeout", 0, 1);
        lt = cyc - last_l;
        rd = res_data;
        if (res_ready) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_dsp_start", dsp_start, 0);
        check("rst_res_data", res_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("cfg_ready_after_rst", cfg_ready, 1);

        // single term, pipe 0
        va[0] = 3; vb[0] = -5;
        send_cfg(2, 1, 10, 0, 1, 0); send_ops(1, 0); wait_res(r, lat);
        check("t1_data", $signed(r), -5);
        check("t1_lat", lat, 3);
        check("t1_starts", st_cnt, 1);

        // three terms, left shift, pipe 2
        va[0] = 1; vb[0] = 2; va[1] = 3; vb[1] = 4; va[2] = 5; vb[2] = 6;
        send_cfg(2, 3, 100, 1, 1, 2); send_ops(3, 0); wait_res(r, lat);
        check("t2_data", $signed(r), 462);
        check("t2_lat", lat, 7);
        check("t2_starts", st_cnt, 3);
        check("t2_runs", st_runs, 1);
        check("t2_setup_mac", setup_mac, 0);

        // right shift, negative values, pipe 1
        va[0] = -4; vb[0] = 8; va[1] = 2; vb[1] = 3;
        send_cfg(1, 2, 0, 1, 0, 1); send_ops(2, 0); wait_res(r, lat);
        check("t3_data", $signed(r), -10);
        check("t3_lat", lat, 5);

        // op_valid bubbles
        va[0] = 1; vb[0] = 2; va[1] = 3; vb[1] = 4; va[2] = 5; vb[2] = 6;
        send_cfg(2, 3, 100, 1, 1, 2); send_ops(3, 2); wait_res(r, lat);
        check("t4_data", $signed(r), 462);
        check("t4_lat", lat, 7);
        check("t4_starts", st_cnt, 3);
        check("t4_runs", st_runs, 1);
        check("t4_setup_mac", setup_mac, 0);

        // backpressure: result held, cfg pulse ignored
        res_ready = 1'b0;
        va[0] = 3; vb[0] = -5;
        send_cfg(2, 1, 10, 0, 1, 1); send_ops(1, 0); wait_res(r, lat);
        check("t5_lat", lat, 4);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", res_valid, 1);
            check("t5_hold_data", $signed(res_data), -5);
            check("t5_cfg_ready", cfg_ready, 0);
            cfg_valid = (i == 1);
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("t5_released", res_valid, 0);
        check("t5_idle", busy, 0);

        // pipe clamp 7 -> 3
        send_cfg(2, 1, 10, 0, 1, 7); send_ops(1, 0); wait_res(r, lat);
        check("t5_clamp_pipe", pipe_seen, 3);
        check("t5_clamp_lat", lat, 6);
        check("t5_clamp_data", $signed(r), -5);

        // reset mid-ISSUE, then a fresh job
        for (int i = 0; i < 8; i++) begin va[i] = 7; vb[i] = 9; end
        send_cfg(2, 8, 0, 0, 1, 3); send_ops(8, 0);
        begin
            int t = 0;
            @(negedge clk);
            while (!dsp_start && t < 20) begin @(negedge clk); t++; end
            if (t >= 20) check("t6_issue_timeout", 0, 1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_start", dsp_start, 0);
        check("t6_rst_mac", dsp_mac, 0);
        check("t6_rst_valid", res_valid, 0);
        rst = 1'b0;
        va[0] = 2; vb[0] = 2;
        send_cfg(2, 1, 1, 0, 1, 0); send_ops(1, 0); wait_res(r, lat);
        check("t6_data", $signed(r), 5);
        check("t6_lat", lat, 3);
        check("t6_starts", st_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Job-level controller in front of the fractured DSP multiply-accumulate slice. It accepts one MAC job: mode, term count, initial addend, shift and pipeline depth. It buffers the job's operand pairs, then issues them to the DSP on consecutive cycles so the DSP's `mac`/`mac_prev` chaining is never broken by a bubble. It tracks the DSP output pipeline depth and returns the final accumulated result over a valid/ready handshake.

## Interface
- WIDTH, 33, DSP operand width; results are 2*WIDTH.
- SHIFT_BITS, 2, width of the accumulate shift amount.
- PIPELINE_BITS, 3, width of the DSP pipe-stage select; it is also the maximum supported depth.
- DEPTH, 8, operand buffer entries, which is the maximum terms per job.
- CNT_BITS, 4, width of the term count; must hold DEPTH.
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid / cfg_ready  in / out  1  job handshake.
- cfg_mode  in  2  DSP mode (00, 01 or 10).
- cfg_len  in  CNT_BITS  terms, 1..DEPTH; 0 is treated as 1 and values >DEPTH as DEPTH.
- cfg_cc  in  2*WIDTH  addend applied to the first term.
- cfg_shift_amount  in  SHIFT_BITS  shift applied to the running sum.
- cfg_shift_dir  in  1  shift direction: 1 = left, 0 = right.
- cfg_pipe  in  PIPELINE_BITS  DSP output depth; values >PIPELINE_BITS are clamped.
- op_valid / op_ready  in / out  1  operand handshake.
- op_a, op_b  in  WIDTH  operand pair.
- res_valid / res_ready  out / in  1  result handshake.
- res_data  out  2*WIDTH  final accumulated value.
- busy  out  1  high whenever the state is not IDLE.
- dsp_start, dsp_mac  out  1  DSP controls.
- dsp_mode  out  2  DSP mode.
- dsp_shift_amount  out  SHIFT_BITS  DSP shift amount.
- dsp_shift_dir  out  1  DSP shift direction.
- dsp_pipe_stages  out  PIPELINE_BITS  DSP pipe-stage select.
- dsp_aa, dsp_bb  out  WIDTH  DSP operands.
- dsp_cc  out  2*WIDTH  DSP addend.
- dsp_out  in  2*WIDTH  DSP result.

## Operation
- States and transitions:
  - IDLE → LOAD on cfg handshake. The job fields are latched with clamping, and the term counter and buffer pointer are cleared.
  - LOAD: op_ready=1. Each op handshake writes {op_a, op_b} into buffer[wr_ptr]. After the cfg_len-th pair → SETUP. Bubbles on op_valid are allowed.
  - SETUP: exactly 1 cycle. dsp_start=0 and dsp_mac=0, which guarantees the DSP's mac_prev=0 at the first issue. dsp_pipe_stages is already driven, because the DSP registers its depth select. → ISSUE.
  - ISSUE: exactly len consecutive cycles. dsp_start=1, dsp_mac=1, and {dsp_aa, dsp_bb}=buffer[idx], with idx incrementing by 1 per cycle. At the last term:
    - if pipe=0, dsp_out is captured into res_data that cycle → DONE;
    - otherwise → DRAIN.
  - DRAIN: the DSP is idle (start=0, mac=0). A down-counter loaded with pipe counts to zero. dsp_out is captured in the pipe-th cycle after the last issue → DONE.
  - DONE: res_valid=1 and res_data is held. On res_ready → IDLE.
- Static DSP fields:
  - dsp_mode, dsp_cc, shift fields and dsp_pipe_stages come from the latched job registers and are constant from SETUP through DONE.
  - In IDLE they hold the previous job's values; after reset they are 0.
- Arithmetic: the DSP performs the arithmetic. The controller adds nothing.
  - Expected result: S1 = a1*b1 + cc; Sk = ak*bk + (S(k-1) shifted).
  - The right shift acts on a sign-extended value, so it is arithmetic.
  - Operand slicing per mode (mode 00: low WIDTH/2+1 bits of a and b; mode 01: low WIDTH/2+1 bits of a) is the DSP's responsibility.
- cfg_ready=1 only in IDLE (and 0 during rst). op_ready=1 only in LOAD. Inputs on an un-readied handshake are ignored.
- Simultaneous events:
  - res_ready in the cycle DONE is entered has no effect until res_valid is visible.
  - A new cfg is accepted the cycle after the result handshake (IDLE).

## Timing
- Reset values: all outputs 0 and state IDLE. cfg_ready rises the first cycle after rst deasserts.
- Reset mid-job: return to IDLE next cycle; the buffer is discarded; res_valid=0; dsp_start=0 and dsp_mac=0.
- Latency, with L = the cycle of the last op handshake:
  - SETUP at L+1; issues at L+2 .. L+1+len.
  - Capture at L+1+len+pipe; res_valid at L+2+len+pipe.
- Throughput: one job per len + pipe + 3 cycles plus load time. Buffer full = len pairs; no overflow is possible.

## Test plan
- Single term: mode 10, len 1, a=3, b=-5, cc=10, pipe 0 → res_data=-5 at L+3.
- Three terms, left shift: mode 10, len 3, pairs (1,2), (3,4), (5,6), cc=100, shift left 1, pipe 2 → 102, 216, 462; res_data=462 at L+7. dsp_start is high for exactly 3 contiguous cycles.
- Right shift with negative values: mode 01, len 2, pairs (-4,8), (2,3), cc=0, shift right 1, pipe 1 → res_data=-10.
- op_valid bubbles: repeat the three-term left-shift scenario with 2-cycle gaps between pairs → same 462; ISSUE still contiguous; SETUP has dsp_mac=0.
- Backpressure and clamping: hold res_ready=0 for 5 cycles → res_data stable, cfg_ready=0, a cfg pulse is ignored. Then cfg_pipe=7 → dsp_pipe_stages=3.
- Reset mid-ISSUE, then a new job (len 1, a=2, b=2, cc=1) → res_data=5 with no residue from the old job.
